serial_rx_frame: RTL and testbench

SERIAL_RX_FRAME -- requirements
Module: serial_rx_frame

---
 rtl/serial_rx_frame.sv | 141 ++++++++++++++
 tb/tb_serial_rx_frame.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_rx_frame.sv
// serial_rx_frame
//   Receives one serial frame per start bit (one bit per clk cycle, idle
//   high): start bit, DATA_BITS data bits, optional parity bit, STOP_BITS
//   stop bits. It holds each good word for a valid/ready consumer.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   S_IDLE     | line idle, waiting for a 0 (start bit)
//   S_DATA     | shifting in data bits, bit_cnt counts samples
//   S_PARITY   | sampling the parity bit (only when PARITY_EN=1)
//   S_STOP     | sampling stop bits, bit_cnt counts stop bits
//   S_ERR_WAIT | bad stop bit seen, waiting for line to return to 1
//
// Ports
//   clk            : clock, rising edge
//   reset          : synchronous active-low reset
//   in             : serial line input
//   out_ready      : consumer accepts held word when out_valid=1
//   out_data       : held word (stable while out_valid=1)
//   out_valid      : held word available until accepted
//   out_parity_err : parity mismatch for held word
//   frame_err      : one-cycle pulse, stop bit sampled as 0
//   overrun        : one-cycle pulse, unaccepted word overwritten
//   busy           : high whenever the FSM is not idle
module serial_rx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int LSB_FIRST  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    output logic                 out_parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    // One spare code so the counter can never wrap inside a frame.
    localparam int CNT_W = $clog2(DATA_BITS + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_DATA     = 3'd1;
    localparam logic [2:0] S_PARITY   = 3'd2;
    localparam logic [2:0] S_STOP     = 3'd3;
    localparam logic [2:0] S_ERR_WAIT = 3'd4;

    logic [2:0]           state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_err;
    logic                 data_last;
    logic                 stop_last;
    logic                 commit;

    assign data_last = (bit_cnt == CNT_W'(DATA_BITS - 1));
    assign stop_last = (bit_cnt == CNT_W'(STOP_BITS - 1));
    assign commit    = (state == S_STOP) && in && stop_last;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_err   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!in) begin
                        state   <= S_DATA;
                        bit_cnt <= '0;
                        par_err <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (LSB_FIRST != 0)
                        shift_reg <= {in, shift_reg[DATA_BITS-1:1]};
                    else
                        shift_reg <= {shift_reg[DATA_BITS-2:0], in};
                    if (data_last) begin
                        bit_cnt <= '0;
                        state   <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    par_err <= (((^shift_reg) ^ in) != 1'(PARITY_ODD));
                    state   <= S_STOP;
                end
                S_STOP: begin
                    if (!in) begin
                        // Any bad stop bit aborts at once; the word is dropped.
                        state     <= S_ERR_WAIT;
                        frame_err <= 1'b1;
                        bit_cnt   <= '0;
                    end else if (stop_last) begin
                        state   <= S_IDLE;
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_ERR_WAIT: begin
                    if (in)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output holding register; a commit always wins over a handshake clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_data       <= '0;
            out_valid      <= 1'b0;
            out_parity_err <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (commit) begin
                out_data       <= shift_reg;
                out_parity_err <= par_err;
                out_valid      <= 1'b1;
                overrun        <= out_valid && !out_ready;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_rx_frame.sv
// Testbench for serial_rx_frame: three instances (defaults, even parity,
// 9-bit/2-stop/MSB-first), scoreboard queues checked by negedge monitors.
module tb_serial_rx_frame;

    typedef struct packed {
        logic [15:0] data;
        logic        perr;
    } exp_t;

    logic clk;
    logic reset;
    logic out_ready;

    logic in_d, in_p, in_n;
    logic [7:0] data_d, data_p;
    logic [8:0] data_n;
    logic v_d, v_p, v_n;
    logic pe_d, pe_p, pe_n;
    logic fe_d, fe_p, fe_n;
    logic ov_d, ov_p, ov_n;
    logic busy_d, busy_p, busy_n;

    exp_t q_d[$];
    exp_t q_p[$];
    exp_t q_n[$];

    int tests = 0;
    int fails = 0;
    int fe_cnt_d = 0, ov_cnt_d = 0, fe_cnt_n = 0;
    int fe_snap, ov_snap;
    bit rdy_flag = 0;

    serial_rx_frame u_def (
        .clk(clk), .reset(reset), .in(in_d), .out_ready(out_ready),
        .out_data(data_d), .out_valid(v_d), .out_parity_err(pe_d),
        .frame_err(fe_d), .overrun(ov_d), .busy(busy_d)
    );

    serial_rx_frame #(.PARITY_EN(1), .PARITY_ODD(0)) u_par (
        .clk(clk), .reset(reset), .in(in_p), .out_ready(out_ready),
        .out_data(data_p), .out_valid(v_p), .out_parity_err(pe_p),
        .frame_err(fe_p), .overrun(ov_p), .busy(busy_p)
    );

    serial_rx_frame #(.DATA_BITS(9), .STOP_BITS(2), .LSB_FIRST(0)) u_nine (
        .clk(clk), .reset(reset), .in(in_n), .out_ready(out_ready),
        .out_data(data_n), .out_valid(v_n), .out_parity_err(pe_n),
        .frame_err(fe_n), .overrun(ov_n), .busy(busy_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: a handshake is seen at negedge, before the edge that takes it.
    always @(negedge clk) begin
        if (reset && v_d && out_ready) begin
            if (q_d.size() == 0) check("def_unexpected_word", {24'd0, data_d}, 32'hFFFF_FFFF);
            else begin
                exp_t e;
                e = q_d.pop_front();
                check("def_data", {24'd0, data_d}, {16'd0, e.data});
                check("def_perr", {31'd0, pe_d}, {31'd0, e.perr});
            end
        end
        if (fe_d) fe_cnt_d++;
        if (ov_d) ov_cnt_d++;
    end

    always @(negedge clk) begin
        if (reset && v_p && out_ready) begin
            if (q_p.size() == 0) check("par_unexpected_word", {24'd0, data_p}, 32'hFFFF_FFFF);
            else begin
                exp_t e;
                e = q_p.pop_front();
                check("par_data", {24'd0, data_p}, {16'd0, e.data});
                check("par_perr", {31'd0, pe_p}, {31'd0, e.perr});
            end
        end
    end

    always @(negedge clk) begin
        if (reset && v_n && out_ready) begin
            if (q_n.size() == 0) check("nine_unexpected_word", {23'd0, data_n}, 32'hFFFF_FFFF);
            else begin
                exp_t e;
                e = q_n.pop_front();
                check("nine_data", {23'd0, data_n}, {16'd0, e.data});
                check("nine_perr", {31'd0, pe_n}, {31'd0, e.perr});
            end
        end
        if (fe_n) fe_cnt_n++;
    end

    task automatic send_bit(input int which, input logic b);
        @(posedge clk);
        #1;
        in_d = 1'b1;
        in_p = 1'b1;
        in_n = 1'b1;
        case (which)
            0:       in_d = b;
            1:       in_p = b;
            default: in_n = b;
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) send_bit(0, 1'b1);
    endtask

    // par < 0 means no parity bit; s0/s1 are the stop bit values.
    task automatic send_frame(input int which, input logic [15:0] data, input int nbits,
                              input bit lsb, input int par, input logic s0, input logic s1,
                              input int nstops);
        send_bit(which, 1'b0);
        for (int i = 0; i < nbits; i++)
            send_bit(which, lsb ? data[i] : data[nbits-1-i]);
        if (par >= 0) send_bit(which, par[0]);
        send_bit(which, s0);
        if (nstops == 2) send_bit(which, s1);
        if (rdy_flag) out_ready = 1'b1;
    endtask

    // Wait for the edge that samples the last driven bit, then look.
    task automatic sample();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        out_ready = 1'b1;
        in_d = 1'b1; in_p = 1'b1; in_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {31'd0, v_d}, 32'd0);
        check("rst_data", {24'd0, data_d}, 32'd0);
        check("rst_busy", {31'd0, busy_d}, 32'd0);
        check("rst_perr", {31'd0, pe_d}, 32'd0);
        check("rst_frame_err", {31'd0, fe_d}, 32'd0);
        check("rst_overrun", {31'd0, ov_d}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Basic frame 0x5A: valid exactly one cycle after the stop bit.
        q_d.push_back('{16'h005A, 1'b0});
        send_frame(0, 16'h005A, 8, 1, -1, 1'b1, 1'b1, 1);
        sample();
        check("basic_latency_valid", {31'd0, v_d}, 32'd1);
        check("basic_busy_idle", {31'd0, busy_d}, 32'd0);
        @(negedge clk);
        check("basic_valid_cleared", {31'd0, v_d}, 32'd0);
        check("basic_data_held", {24'd0, data_d}, 32'h5A);
        idle(2);

        // Bad stop bit, then line held low for 3 cycles before returning high.
        fe_snap = fe_cnt_d;
        send_frame(0, 16'h005A, 8, 1, -1, 1'b0, 1'b1, 1);
        send_bit(0, 1'b0);
        send_bit(0, 1'b0);
        send_bit(0, 1'b0);
        sample();
        check("errwait_busy", {31'd0, busy_d}, 32'd1);
        send_bit(0, 1'b1);
        sample();
        check("errwait_left", {31'd0, busy_d}, 32'd0);
        check("badstop_no_valid", {31'd0, v_d}, 32'd0);
        check("badstop_fe_pulses", fe_cnt_d - fe_snap, 32'd1);
        idle(2);

        // Back-to-back with out_ready=0: 0x11 overwritten by 0x22.
        out_ready = 1'b0;
        ov_snap = ov_cnt_d;
        q_d.push_back('{16'h0022, 1'b0});
        send_frame(0, 16'h0011, 8, 1, -1, 1'b1, 1'b1, 1);
        send_frame(0, 16'h0022, 8, 1, -1, 1'b1, 1'b1, 1);
        sample();
        check("b2b_valid", {31'd0, v_d}, 32'd1);
        check("b2b_data", {24'd0, data_d}, 32'h22);
        @(negedge clk);
        @(negedge clk);
        check("b2b_overrun_once", ov_cnt_d - ov_snap, 32'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        idle(3);

        // Back-to-back with out_ready rising for the second commit: no overrun.
        out_ready = 1'b0;
        ov_snap = ov_cnt_d;
        q_d.push_back('{16'h0011, 1'b0});
        q_d.push_back('{16'h0022, 1'b0});
        send_frame(0, 16'h0011, 8, 1, -1, 1'b1, 1'b1, 1);
        rdy_flag = 1;
        send_frame(0, 16'h0022, 8, 1, -1, 1'b1, 1'b1, 1);
        rdy_flag = 0;
        idle(3);
        check("b2b_ready_no_overrun", ov_cnt_d - ov_snap, 32'd0);
        check("b2b_ready_drained", q_d.size(), 32'd0);

        // Mid-frame reset after the 4th data bit.
        fe_snap = fe_cnt_d;
        ov_snap = ov_cnt_d;
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        send_bit(0, 1'b1);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        @(posedge clk);
        #1;
        in_d = 1'b1;
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", {31'd0, busy_d}, 32'd0);
        check("midrst_valid", {31'd0, v_d}, 32'd0);
        check("midrst_data_zero", {24'd0, data_d}, 32'd0);
        q_d.push_back('{16'h00C3, 1'b0});
        send_frame(0, 16'h00C3, 8, 1, -1, 1'b1, 1'b1, 1);
        sample();
        check("midrst_next_valid", {31'd0, v_d}, 32'd1);
        idle(2);
        check("midrst_no_fe", fe_cnt_d - fe_snap, 32'd0);
        check("midrst_no_ov", ov_cnt_d - ov_snap, 32'd0);

        // Even parity on 0x03 (two ones): parity bit 1 is wrong, 0 is right.
        q_p.push_back('{16'h0003, 1'b1});
        send_frame(1, 16'h0003, 8, 1, 1, 1'b1, 1'b1, 1);
        sample();
        check("par_err_valid", {31'd0, v_p}, 32'd1);
        q_p.push_back('{16'h0003, 1'b0});
        send_frame(1, 16'h0003, 8, 1, 0, 1'b1, 1'b1, 1);
        sample();
        check("par_ok_valid", {31'd0, v_p}, 32'd1);
        idle(2);

        // 9 bits, MSB first, second stop bit bad, then a clean resend.
        fe_snap = fe_cnt_n;
        send_frame(2, 16'h01A5, 9, 0, -1, 1'b1, 1'b0, 2);
        sample();
        check("nine_badstop_no_valid", {31'd0, v_n}, 32'd0);
        idle(3);
        check("nine_badstop_fe", fe_cnt_n - fe_snap, 32'd1);
        q_n.push_back('{16'h01A5, 1'b0});
        send_frame(2, 16'h01A5, 9, 0, -1, 1'b1, 1'b1, 2);
        sample();
        check("nine_valid", {31'd0, v_n}, 32'd1);
        check("nine_data_direct", {23'd0, data_n}, 32'h1A5);
        idle(4);

        check("q_def_empty", q_d.size(), 32'd0);
        check("q_par_empty", q_p.size(), 32'd0);
        check("q_nine_empty", q_n.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
